// File: rtl/mem_arb2.sv
// mem_arb2: two-requester round-robin front end for one single-port memory.
// Serialises requests, routes read data back to the issuer and aborts any
// memory access that stalls past the watchdog limit, flagging it as an error.
//
//   state | meaning
//   IDLE  | waiting for a request; arbitrates and launches the memory access
//   BUSY  | memory access outstanding; watchdog running
//   RESP  | one-cycle ready (and err on timeout) pulse to the granted requester
module mem_arb2 #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 256,
  parameter int ADDR    = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  input  logic             r0_wrbar,
  input  logic [ADDR-1:0]  r0_addr,
  input  logic [WIDTH-1:0] r0_wdata,
  output logic             r0_ready,
  output logic             r0_err,
  output logic [WIDTH-1:0] r0_rdata,
  input  logic             r1_valid,
  input  logic             r1_wrbar,
  input  logic [ADDR-1:0]  r1_addr,
  input  logic [WIDTH-1:0] r1_wdata,
  output logic             r1_ready,
  output logic             r1_err,
  output logic [WIDTH-1:0] r1_rdata,
  output logic             mem_valid,
  output logic             mem_wrbar,
  output logic [ADDR-1:0]  mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready
);

  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  // DEPTH only documents the memory size; reject a memory the address cannot reach.
  if (DEPTH > (1 << ADDR)) begin : g_depth_check
    $error("mem_arb2: DEPTH exceeds the ADDR address range");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t           state, state_n;
  logic             gnt, gnt_n;
  logic             last, last_n;
  logic             pick;
  logic [WDW-1:0]   wd, wd_n;
  logic             mem_valid_n, mem_wrbar_n;
  logic [ADDR-1:0]  mem_addr_n;
  logic [WIDTH-1:0] mem_wdata_n;
  logic             r0_ready_n, r1_ready_n, r0_err_n, r1_err_n;
  logic [WIDTH-1:0] r0_rdata_n, r1_rdata_n;

  // State and all registered outputs; reset leaves requester 0 winning the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      last      <= 1'b1;
      wd        <= '0;
      mem_valid <= 1'b0;
      mem_wrbar <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      r0_ready  <= 1'b0;
      r1_ready  <= 1'b0;
      r0_err    <= 1'b0;
      r1_err    <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      last      <= last_n;
      wd        <= wd_n;
      mem_valid <= mem_valid_n;
      mem_wrbar <= mem_wrbar_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      r0_ready  <= r0_ready_n;
      r1_ready  <= r1_ready_n;
      r0_err    <= r0_err_n;
      r1_err    <= r1_err_n;
      r0_rdata  <= r0_rdata_n;
      r1_rdata  <= r1_rdata_n;
    end
  end

  // Arbitration, watchdog and response generation; ready/err default low so they pulse.
  always_comb begin
    state_n     = state;
    gnt_n       = gnt;
    last_n      = last;
    wd_n        = wd;
    mem_valid_n = mem_valid;
    mem_wrbar_n = mem_wrbar;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    r0_ready_n  = 1'b0;
    r1_ready_n  = 1'b0;
    r0_err_n    = 1'b0;
    r1_err_n    = 1'b0;
    r0_rdata_n  = r0_rdata;
    r1_rdata_n  = r1_rdata;
    pick        = (r0_valid && r1_valid) ? ~last : r1_valid;

    case (state)
      IDLE: begin
        if (r0_valid || r1_valid) begin
          gnt_n       = pick;
          mem_wrbar_n = pick ? r1_wrbar : r0_wrbar;
          mem_addr_n  = pick ? r1_addr  : r0_addr;
          mem_wdata_n = pick ? r1_wdata : r0_wdata;
          mem_valid_n = 1'b1;
          wd_n        = '0;
          state_n     = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          mem_valid_n = 1'b0;
          state_n     = RESP;
          if (gnt) begin
            r1_rdata_n = mem_rdata;
            r1_ready_n = 1'b1;
          end else begin
            r0_rdata_n = mem_rdata;
            r0_ready_n = 1'b1;
          end
        end else if (wd == WD_LAST) begin
          mem_valid_n = 1'b0;
          state_n     = RESP;
          if (gnt) begin
            r1_rdata_n = '0;
            r1_ready_n = 1'b1;
            r1_err_n   = 1'b1;
          end else begin
            r0_rdata_n = '0;
            r0_ready_n = 1'b1;
            r0_err_n   = 1'b1;
          end
        end else begin
          wd_n = wd + WDW'(1);
        end
      end
      RESP: begin
        last_n  = gnt;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arb2.sv
// Bench for mem_arb2: directed sequence with random data, a behavioural
// memory and a reference model of grant order and expected read data.
module tb_mem_arb2;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        r0_valid = 1'b0, r1_valid = 1'b0;
  logic        r0_wrbar = 1'b0, r1_wrbar = 1'b0;
  logic [7:0]  r0_addr = '0, r1_addr = '0;
  logic [31:0] r0_wdata = '0, r1_wdata = '0;
  logic        r0_ready, r1_ready, r0_err, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic        mem_valid, mem_wrbar;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // memory contents as seen by the emulated memory, and as the model expects them
  logic [31:0] mem_arr [256];
  logic [31:0] ref_mem [256];
  int last_srv = 1;
  int cnt0 = 0, cnt1 = 0;

  mem_arb2 #(.WIDTH(32), .DEPTH(256), .ADDR(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_wrbar(r0_wrbar), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ready(r0_ready), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_wrbar(r1_wrbar), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ready(r1_ready), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .mem_valid(mem_valid), .mem_wrbar(mem_wrbar), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction from the requester inputs currently applied. lat = memory
  // wait cycles before mem_ready; tmo = memory never answers.
  task automatic txn(input int lat, input bit tmo);
    int          g;
    logic        ew;
    logic [7:0]  ea;
    logic [31:0] ed, junk, er;
    int          wait_cyc;
    g  = (r0_valid && r1_valid) ? (last_srv == 1 ? 0 : 1) : (r1_valid ? 1 : 0);
    ew = g ? r1_wrbar : r0_wrbar;
    ea = g ? r1_addr  : r0_addr;
    ed = g ? r1_wdata : r0_wdata;
    wait_cyc = tmo ? TIMEOUT - 1 : lat;
    @(negedge clk);
    chk("launch_mem_valid", {31'b0, mem_valid}, 32'd1);
    chk("launch_mem_addr", {24'b0, mem_addr}, {24'b0, ea});
    chk("launch_mem_wrbar", {31'b0, mem_wrbar}, {31'b0, ew});
    if (ew) chk("launch_mem_wdata", mem_wdata, ed);
    for (int i = 0; i < wait_cyc; i++) begin
      @(negedge clk);
      chk("busy_mem_valid", {31'b0, mem_valid}, 32'd1);
      chk("busy_addr_stable", {24'b0, mem_addr}, {24'b0, ea});
      chk("busy_no_ready", {30'b0, r1_ready, r0_ready}, 32'd0);
    end
    if (!tmo) begin
      junk = $urandom;
      mem_rdata = mem_wrbar ? junk : mem_arr[mem_addr];
      if (mem_wrbar) mem_arr[mem_addr] = mem_wdata;
      mem_ready = 1'b1;
      er = ew ? junk : ref_mem[ea];
    end else begin
      er = 32'd0;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    chk("resp_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("resp_ready", {30'b0, r1_ready, r0_ready}, g ? 32'd2 : 32'd1);
    chk("resp_err", {30'b0, r1_err, r0_err}, tmo ? (g ? 32'd2 : 32'd1) : 32'd0);
    chk("resp_rdata", g ? r1_rdata : r0_rdata, er);
    if (r0_ready) cnt0++;
    if (r1_ready) cnt1++;
    if (ew && !tmo) ref_mem[ea] = ed;
    last_srv = g;
    @(negedge clk);
    chk("pulse_end", {28'b0, r1_err, r0_err, r1_ready, r0_ready}, 32'd0);
    chk("rdata_hold", g ? r1_rdata : r0_rdata, er);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      mem_arr[a] = $urandom;
      ref_mem[a] = mem_arr[a];
    end

    // reset held with both requesters valid
    r0_valid = 1'b1; r0_wrbar = 1'b0; r0_addr = 8'h01;
    r1_valid = 1'b1; r1_wrbar = 1'b0; r1_addr = 8'h02;
    repeat (2) @(negedge clk);
    chk("rst_mem", {mem_valid, mem_wrbar, mem_addr, 22'b0}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rsp", {28'b0, r1_err, r0_err, r1_ready, r0_ready}, 32'd0);
    chk("rst_rdata", r0_rdata | r1_rdata, 32'd0);
    rst = 1'b1;
    txn(0, 1'b0);
    r0_valid = 1'b0; r1_valid = 1'b0;

    // mem_ready outside BUSY does nothing
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("idle_ready_ignored", {29'b0, mem_valid, r1_ready, r0_ready}, 32'd0);

    // single writer, addresses 0..31
    cnt0 = 0; cnt1 = 0;
    for (int a = 0; a < 32; a++) begin
      r0_valid = 1'b1; r0_wrbar = 1'b1; r0_addr = 8'(a); r0_wdata = $urandom;
      txn(1, 1'b0);
    end
    r0_valid = 1'b0;
    chk("writer_r0_count", cnt0, 32'd32);
    chk("writer_r1_count", cnt1, 32'd0);

    // readback from requester 1 with random memory latency
    for (int a = 0; a < 32; a++) begin
      r1_valid = 1'b1; r1_wrbar = 1'b0; r1_addr = 8'(a);
      txn($urandom_range(0, 3), 1'b0);
    end
    r1_valid = 1'b0;

    // contention: both continuously valid
    cnt0 = 0; cnt1 = 0;
    r0_valid = 1'b1; r0_wrbar = 1'b0; r0_addr = 8'h10;
    r1_valid = 1'b1; r1_wrbar = 1'b0; r1_addr = 8'h20;
    for (int i = 0; i < 8; i++) txn($urandom_range(0, 2), 1'b0);
    r0_valid = 1'b0; r1_valid = 1'b0;
    chk("contend_r0_count", cnt0, 32'd4);
    chk("contend_r1_count", cnt1, 32'd4);

    // timeout, then a normal access, then mem_ready on the last watchdog cycle
    r0_valid = 1'b1; r0_wrbar = 1'b0; r0_addr = 8'h05;
    txn(0, 1'b1);
    txn(0, 1'b0);
    txn(TIMEOUT - 1, 1'b0);
    r0_valid = 1'b0;

    // random mixed traffic
    for (int i = 0; i < 20; i++) begin
      r0_valid = 1'($urandom_range(0, 1)); r0_wrbar = 1'($urandom);
      r0_addr = 8'($urandom_range(0, 63)); r0_wdata = $urandom;
      r1_valid = 1'($urandom_range(0, 1)); r1_wrbar = 1'($urandom);
      r1_addr = 8'($urandom_range(0, 63)); r1_wdata = $urandom;
      if (!r0_valid && !r1_valid) r1_valid = 1'b1;
      txn($urandom_range(0, 4), 1'b0);
    end
    r0_valid = 1'b0; r1_valid = 1'b0;

    // reset in the middle of a transaction
    r1_valid = 1'b1; r1_wrbar = 1'b0; r1_addr = 8'h03;
    @(negedge clk);
    chk("midrst_launch", {31'b0, mem_valid}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("midrst_no_ready", {30'b0, r1_ready, r0_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1; r1_valid = 1'b0;
    last_srv = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_quiet", {29'b0, mem_valid, r1_ready, r0_ready}, 32'd0);
    end
    r0_valid = 1'b1; r0_wrbar = 1'b0; r0_addr = 8'h07;
    r1_valid = 1'b1; r1_wrbar = 1'b0; r1_addr = 8'h03;
    txn(0, 1'b0);
    r0_valid = 1'b0;
    txn(1, 1'b0);
    r1_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arb2.md
# mem_arb2

Two-port round-robin arbiter that shares one single-port `memory` instance (valid/ready, `wrbar` = 1 for write) between two requesters.
- Sits between two masters (for example a DMA engine and a CPU-side loader) and the memory.
- Serialises their transactions and returns read data to the requester that issued them.
- A watchdog aborts any memory transaction that never completes and reports it as an error.

## Interface
- WIDTH, 32, data width
- DEPTH, 256, memory depth (documentation only; address range is 0..DEPTH-1)
- ADDR, 8, address width
- TIMEOUT, 16, max cycles the arbiter waits for mem_ready before aborting (>=2)

- clk  in  1  clock; all state changes on posedge
- rst  in  1  asynchronous, active-low reset
- r0_valid, r1_valid  in  1  request valid from requester 0/1
- r0_wrbar, r1_wrbar  in  1  1 = write, 0 = read
- r0_addr, r1_addr  in  ADDR  request address
- r0_wdata, r1_wdata  in  WIDTH  write data
- r0_ready, r1_ready  out  1  one-cycle completion pulse
- r0_err, r1_err  out  1  one-cycle timeout pulse, coincident with the matching ready
- r0_rdata, r1_rdata  out  WIDTH  read data; valid while the matching ready is high
- mem_valid  out  1  request to memory
- mem_wrbar  out  1  forwarded command
- mem_addr  out  ADDR  forwarded address
- mem_wdata  out  WIDTH  forwarded write data
- mem_rdata  in  WIDTH  memory read data
- mem_ready  in  1  memory completion

## Operation
- FSM states: IDLE, BUSY, RESP. All outputs are registered.
- **IDLE**
  - No valid requests: stay in IDLE.
  - One requester valid: grant it.
  - Both valid: grant the requester not served last.
  - Latch the granted command (wrbar/addr/wdata) into the mem_* registers, set mem_valid=1, clear the watchdog counter, go to BUSY.
- **BUSY**
  - Hold mem_* stable; the watchdog counter increments each cycle.
  - mem_ready=1 sampled: capture mem_rdata into the granted rN_rdata (write transactions also capture), set mem_valid=0, go to RESP.
  - Else watchdog reaches TIMEOUT-1: set mem_valid=0, set rN_rdata=0, flag error, go to RESP.
  - mem_ready has priority over the timeout when both occur on the same edge.
- **RESP**
  - rN_ready=1 (and rN_err=1 if flagged) for exactly one cycle; update last-served = granted index; return to IDLE.
- **Requester rule:** hold valid and the command stable until ready is seen. A valid still high on the edge after ready is treated as a new transaction, sampled in IDLE.
- **Fairness:** with both requesters continuously valid, grants strictly alternate 0,1,0,1...
- The non-granted requester's inputs are ignored and its ready stays 0.
- r0_rdata/r1_rdata hold their last value outside ready cycles.
- A request that drops valid while granted is still completed; the ready pulse is still issued.

## Timing
- **Reset (rst=0, asynchronous):**
  - State IDLE; last-served = 1, so requester 0 wins the first tie.
  - mem_valid=0, mem_wrbar=0, mem_addr=0, mem_wdata=0.
  - r0/r1_ready=0, r0/r1_err=0, r0/r1_rdata=0; watchdog=0.
  - Reset mid-transaction drops mem_valid immediately and no ready is issued.
- **Request latency:** valid sampled at edge N gives mem_valid=1 after edge N.
- **Completion latency:** mem_ready sampled at edge M gives rN_ready=1 after edge M, low after edge M+1.
- **Zero-wait memory** (mem_ready high on the first BUSY edge): 3 cycles per transaction. Back-to-back throughput is one transaction per 3 cycles.
- **Timeout:** mem_valid stays high for exactly TIMEOUT cycles, then the err/ready pulse follows on the next cycle.
- mem_ready while not in BUSY is ignored.

## Test plan
- **Reset:** hold rst=0 for 2 cycles with both valids high → all outputs 0 and no mem_valid; after release, requester 0 is granted first.
- **Single writer:** r0 writes addr 0..31 with $random data, memory ready after 1 cycle → 32 ready pulses on r0, mem_addr sequence 0..31, r1_ready never high.
- **Readback:** r1 reads addr 0..31 after the writes → r1_rdata matches the data written at each address on every r1_ready pulse.
- **Contention:** both requesters continuously valid, r0 at addr 8'h10, r1 at 8'h20, 8 transactions → mem_addr alternates 10,20,10,20..., each requester gets 4 ready pulses.
- **Timeout:** memory ready tied 0, r0 reads addr 5, TIMEOUT=16 → mem_valid high for 16 cycles, then r0_ready=r0_err=1 for one cycle with r0_rdata=0; the next request proceeds normally.
- **Mid-op reset:** assert rst while in BUSY → mem_valid=0 immediately, no ready pulse; the following transaction completes correctly.
